// File: rtl/mem_access_ctrl.sv
// Arbitrates the single memory port between instruction fetch and data accesses, one access
// at a time with a ready-based wait handshake. Optional access timeout: define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] DATA_RD = 3'd2;
  localparam logic [2:0] DATA_WR = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              last_data_q, last_data_d;  // 1 = most recent grant went to data
  logic              ack_fetch_q, ack_fetch_d;  // which requester owns the DONE ack
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              grant_data;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wait_inc;
  logic       timeout_err_q, timeout_err_d;
  assign wait_inc = wait_cnt_q + 8'd1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Under contention data wins unless it also won last time, so fetch cannot starve.
  assign grant_data = data_req && (!fetch_req || !last_data_q);

  always_comb begin
    state_d      = state_q;
    last_data_d  = last_data_q;
    ack_fetch_d  = ack_fetch_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_req || fetch_req) begin
`ifdef MEM_TIMEOUT_EN
          wait_cnt_d = 8'd0;
`endif
          if (grant_data) begin
            last_data_d = 1'b1;
            ack_fetch_d = 1'b0;
            mem_addr_d  = data_addr;
            if (data_we) begin
              mem_wdata_d = data_wdata;
              state_d     = DATA_WR;
            end else begin
              state_d = DATA_RD;
            end
          end else begin
            last_data_d = 1'b0;
            ack_fetch_d = 1'b1;
            mem_addr_d  = fetch_addr;
            state_d     = FETCH;
          end
        end
      end
      FETCH, DATA_RD, DATA_WR: begin
        if (mem_ready) begin
          if (state_q == FETCH)   fetch_data_d = mem_rdata;
          if (state_q == DATA_RD) data_rdata_d = mem_rdata;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_inc == 8'(TIMEOUT_CYCLES)) begin
          // Abort looks like a normal completion returning all-ones.
          if (state_q == FETCH)   fetch_data_d = '1;
          if (state_q == DATA_RD) data_rdata_d = '1;
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end else begin
          wait_cnt_d = wait_inc;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_data_q  <= 1'b0;
      ack_fetch_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_data_q  <= last_data_d;
      ack_fetch_q  <= ack_fetch_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign fetch_data = fetch_data_q;
  assign data_rdata = data_rdata_q;
  assign mem_rd     = (state_q == FETCH) || (state_q == DATA_RD);
  assign mem_wr     = (state_q == DATA_WR);
  assign busy       = (state_q != IDLE);
  assign fetch_ack  = (state_q == DONE) && ack_fetch_q;
  assign data_ack   = (state_q == DONE) && !ack_fetch_q;
`ifdef MEM_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; timeout scenario runs when MEM_TIMEOUT_EN
// is defined.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, data_req, data_we, mem_ready;
  logic [15:0] fetch_addr, data_addr, data_wdata, mem_rdata;
  logic        fetch_ack, data_ack, mem_rd, mem_wr, busy, timeout_err;
  logic [15:0] fetch_data, data_rdata, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack),
    .fetch_data(fetch_data),
    .data_req(data_req),
    .data_we(data_we),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_ack(data_ack),
    .data_rdata(data_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic exp_data;
    reset = 1'b1; fetch_req = 0; data_req = 0; data_we = 0; mem_ready = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
    do_reset();

    // Reset state
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd", mem_rd, 0);
    check_eq("rst_wr", mem_wr, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_fdata", fetch_data, 0);
    check_eq("rst_drdata", data_rdata, 0);
    check_eq("rst_acks", {fetch_ack, data_ack}, 0);
    check_eq("rst_terr", timeout_err, 0);

    // Fetch only, zero wait
    fetch_req = 1; fetch_addr = 16'h0040;
    tick();
    check_eq("f_rd", mem_rd, 1);
    check_eq("f_addr", mem_addr, 16'h0040);
    check_eq("f_ack_early", fetch_ack, 0);
    mem_ready = 1; mem_rdata = 16'h1234;
    tick();
    check_eq("f_rd_drop", mem_rd, 0);
    check_eq("f_ack", fetch_ack, 1);
    check_eq("f_dack", data_ack, 0);
    check_eq("f_data", fetch_data, 16'h1234);
    fetch_req = 0; mem_ready = 0;
    tick();
    check_eq("f_idle", busy, 0);
    check_eq("f_ack_gone", fetch_ack, 0);

    // Data write with three wait cycles; inputs change after grant to prove sampling
    data_req = 1; data_we = 1; data_addr = 16'h0100; data_wdata = 16'hBEEF;
    tick();
    data_addr = 16'hFFFF; data_wdata = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      check_eq("w_wr", mem_wr, 1);
      check_eq("w_rd", mem_rd, 0);
      check_eq("w_addr", mem_addr, 16'h0100);
      check_eq("w_wdata", mem_wdata, 16'hBEEF);
      check_eq("w_noack", data_ack, 0);
      if (i == 3) mem_ready = 1;
      tick();
    end
    check_eq("w_wr_drop", mem_wr, 0);
    check_eq("w_ack", data_ack, 1);
    check_eq("w_fack", fetch_ack, 0);
    check_eq("w_fdata_kept", fetch_data, 16'h1234);
    data_req = 0; data_we = 0; mem_ready = 0;
    tick();
    check_eq("w_ack_once", data_ack, 0);
    check_eq("w_idle", busy, 0);

    // mem_ready in IDLE is ignored
    mem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("ri_busy", busy, 0);
      check_eq("ri_strobes", {mem_rd, mem_wr}, 0);
      check_eq("ri_acks", {fetch_ack, data_ack}, 0);
    end
    mem_ready = 0;

    // Reset clears captured data and the last-grant history
    do_reset();
    check_eq("rst2_fdata", fetch_data, 0);

    // Contention, zero-wait memory: data, fetch, data, fetch
    fetch_req = 1; fetch_addr = 16'h0200;
    data_req = 1; data_we = 0; data_addr = 16'h0300;
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_data = (k % 2 == 0);
      mem_rdata = 16'hA000 + 16'(k);
      tick();
      check_eq("c_addr", mem_addr, exp_data ? 16'h0300 : 16'h0200);
      check_eq("c_rd", mem_rd, 1);
      tick();
      check_eq("c_dack", data_ack, exp_data);
      check_eq("c_fack", fetch_ack, !exp_data);
      if (exp_data) check_eq("c_drdata", data_rdata, 16'hA000 + 16'(k));
      else          check_eq("c_fdata", fetch_data, 16'hA000 + 16'(k));
      tick();
      check_eq("c_idle", busy, 0);
      check_eq("c_acks_off", {fetch_ack, data_ack}, 0);
    end
    fetch_req = 0; data_req = 0; mem_ready = 0;
    tick();

    // Reset during a DATA_RD wait
    data_req = 1; data_we = 0; data_addr = 16'h0400;
    tick();
    check_eq("r_rd", mem_rd, 1);
    tick();
    reset = 1; mem_rdata = 16'h5555;
    tick();
    check_eq("r_busy", busy, 0);
    check_eq("r_rd_drop", mem_rd, 0);
    check_eq("r_noack", data_ack, 0);
    check_eq("r_drdata", data_rdata, 0);
    reset = 0; data_req = 0;
    tick();
    check_eq("r_noack2", data_ack, 0);

`ifdef MEM_TIMEOUT_EN
    // Fetch against a memory that never answers
    fetch_req = 1; fetch_addr = 16'h0500; mem_ready = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t_rd", mem_rd, 1);
      tick();
    end
    check_eq("t_ack", fetch_ack, 1);
    check_eq("t_fdata", fetch_data, 16'hFFFF);
    check_eq("t_err", timeout_err, 1);
    fetch_req = 0;
    tick();
    fetch_req = 1; fetch_addr = 16'h0600;
    tick();
    mem_ready = 1; mem_rdata = 16'h7777;
    tick();
    check_eq("t_ack2", fetch_ack, 1);
    check_eq("t_fdata2", fetch_data, 16'h7777);
    fetch_req = 0; mem_ready = 0;
    tick();
    check_eq("t_err_sticky", timeout_err, 1);
`else
    check_eq("noto_terr", timeout_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
